// File: rtl/bytebeat_sequencer.sv
// Sample-rate scheduler for the bytebeat datapath: prescaler tick, time counter t,
// start/done launch handshake, sample latch, config registers and overrun counter.
module bytebeat_sequencer #(
  parameter int          DIV_W     = 16,
  parameter int          T_W       = 24,
  parameter logic [15:0] DIV_RESET = 16'd1249
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [1:0]     cfg_addr,
  input  logic [7:0]     cfg_data,
  output logic           eval_start,
  output logic [T_W-1:0] eval_t,
  output logic [2:0]     eval_sel,
  input  logic           eval_done,
  input  logic [7:0]     eval_sample,
  output logic [7:0]     sample_out,
  output logic           sample_valid,
  output logic [7:0]     overrun,
  output logic           busy
);

  // Config handshake: a write lands on any edge where cfg_valid && cfg_ready;
  // cfg_ready drops only while an evaluation is outstanding.
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_busy;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             r_run;
  logic [2:0]       r_sel;
  logic [T_W-1:0]   r_t;
  logic [7:0]       r_overrun;
  logic             r_eval_start;
  logic [T_W-1:0]   r_eval_t;
  logic [7:0]       r_sample_out;
  logic             r_sample_valid;

  logic             w_cfg_fire;
  logic             w_clear;
  logic             w_tick;
  logic             w_launch;
  logic             w_drop;
  logic             w_finish;
  logic [15:0]      w_div_ext;
  logic [15:0]      w_div_new;

  assign w_cfg_fire = cfg_valid & ~w_busy;
  assign w_clear    = w_cfg_fire & (cfg_addr == 2'd3);
  // >= lets a freshly lowered divider wrap on the next enabled cycle
  assign w_tick     = r_run & ena & (r_cnt >= r_div);
  assign w_launch   = w_tick & ~w_busy;
  assign w_drop     = w_tick & w_busy;
  assign w_finish   = eval_done & w_busy;

  // Divider is written as two bytes; bits at and above DIV_W (at most 16) are discarded.
  assign w_div_ext = 16'(r_div);
  always_comb begin
    w_div_new = w_div_ext;
    if (w_cfg_fire && cfg_addr == 2'd0) w_div_new[7:0]  = cfg_data;
    if (w_cfg_fire && cfg_addr == 2'd1) w_div_new[15:8] = cfg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_tick)    w_next = S_BUSY;
      S_BUSY:  if (eval_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= DIV_RESET[DIV_W-1:0];
      r_run <= 1'b0;
      r_sel <= 3'd0;
    end else begin
      r_div <= w_div_new[DIV_W-1:0];
      if (w_cfg_fire && cfg_addr == 2'd2) begin
        r_sel <= cfg_data[2:0];
        r_run <= cfg_data[7];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!r_run) begin
      r_cnt <= '0;
    end else if (ena) begin
      r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
    end
  end

  // t advances on every tick, dropped or not, so pitch survives overruns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t       <= '0;
      r_overrun <= 8'd0;
    end else if (w_clear) begin
      r_t       <= '0;
      r_overrun <= 8'd0;
    end else begin
      if (w_tick) r_t <= r_t + T_W'(1);
      if (w_drop && r_overrun != 8'hFF) r_overrun <= r_overrun + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eval_start   <= 1'b0;
      r_eval_t       <= '0;
      r_sample_out   <= 8'd0;
      r_sample_valid <= 1'b0;
    end else begin
      r_eval_start   <= w_launch;
      r_sample_valid <= w_finish;
      if (w_launch) r_eval_t     <= r_t;
      if (w_finish) r_sample_out <= eval_sample;
    end
  end

  assign cfg_ready    = ~w_busy;
  assign busy         = w_busy;
  assign eval_start   = r_eval_start;
  assign eval_t       = r_eval_t;
  assign eval_sel     = r_sel;
  assign sample_out   = r_sample_out;
  assign sample_valid = r_sample_valid;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_bytebeat_sequencer.sv
// Directed bench for bytebeat_sequencer: inputs change and outputs are checked on the
// falling edge; the datapath is emulated by tasks answering eval_start.
module tb_bytebeat_sequencer;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        eval_start;
  logic [23:0] eval_t;
  logic [2:0]  eval_sel;
  logic        eval_done;
  logic [7:0]  eval_sample;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic [7:0]  overrun;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int prev_cyc;
  int last_wait;
  logic [23:0] prev_t;
  logic        saw_start;

  bytebeat_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .eval_start(eval_start), .eval_t(eval_t), .eval_sel(eval_sel),
    .eval_done(eval_done), .eval_sample(eval_sample),
    .sample_out(sample_out), .sample_valid(sample_valid),
    .overrun(overrun), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    while (cfg_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_accept_wait", 32'(n < 100), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (eval_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    chk(tag, 32'(eval_start), 32'd1);
  endtask

  // Called on the falling edge of the start cycle; eval_done is sampled on the
  // delay-th rising edge after the launching edge.
  task automatic dp_answer(input int delay, input logic [7:0] smp);
    repeat (delay - 1) @(negedge clk);
    eval_done   = 1'b1;
    eval_sample = smp;
    @(negedge clk);
    eval_done = 1'b0;
    chk("sample_valid", 32'(sample_valid), 32'd1);
    chk("sample_out", 32'(sample_out), 32'(smp));
    chk("busy_fall", 32'(busy), 32'd0);
  endtask

  task automatic stop_run();
    cfg_write(2'd2, 8'h05);
    if (eval_start === 1'b1) dp_answer(1, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; cfg_valid = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0;
    eval_done = 1'b0; eval_sample = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_eval_start", 32'(eval_start), 32'd0);
    chk("rst_eval_t", 32'(eval_t), 32'd0);
    chk("rst_sample_out", 32'(sample_out), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // div=3, sel=5: launch every 4 cycles, quick datapath
    cfg_write(2'd0, 8'd3);
    cfg_write(2'd1, 8'd0);
    cfg_write(2'd2, 8'h85);
    for (int i = 0; i < 4; i++) begin
      wait_start("t1_start");
      chk("t1_eval_t", 32'(eval_t), 32'(i));
      chk("t1_eval_sel", 32'(eval_sel), 32'd5);
      chk("t1_busy", 32'(busy), 32'd1);
      if (i > 0) chk("t1_spacing", 32'(cyc - prev_cyc), 32'd4);
      prev_cyc = cyc;
      dp_answer(1, 8'(i * 3));
      chk("t1_overrun", 32'(overrun), 32'd0);
    end

    // div=1, slow datapath: two drops per launch, eval_t steps by 3
    cfg_write(2'd0, 8'd1);
    for (int i = 0; i < 4; i++) begin
      wait_start("t2_start");
      if (i > 0) chk("t2_eval_t_step", 32'(eval_t - prev_t), 32'd3);
      prev_t = eval_t;
      dp_answer(5, 8'(8'h40 + i));
      chk("t2_overrun", 32'(overrun), 32'(2 * (i + 1)));
    end
    wait_start("t2_hold_start");
    repeat (20) @(negedge clk);
    chk("t2_overrun_mid", 32'(overrun), 32'd18);
    repeat (580) @(negedge clk);
    chk("t2_overrun_sat", 32'(overrun), 32'd255);
    dp_answer(1, 8'h99);
    stop_run();

    // div=0: done coincides with a tick
    cfg_write(2'd3, 8'd0);
    chk("t3_clear_overrun", 32'(overrun), 32'd0);
    cfg_write(2'd0, 8'd0);
    cfg_write(2'd2, 8'h85);
    for (int i = 0; i < 3; i++) begin
      wait_start("t3_start");
      chk("t3_eval_t", 32'(eval_t), 32'(2 * i));
      if (i > 0) chk("t3_spacing", 32'(cyc - prev_cyc), 32'd2);
      prev_cyc = cyc;
      dp_answer(1, 8'(8'h10 + i));
      chk("t3_overrun", 32'(overrun), 32'(i + 1));
    end
    stop_run();
    chk("t3_overrun_final", 32'(overrun), 32'd3);

    // clear coinciding with the launch at t=10, then a write held off by busy
    cfg_write(2'd0, 8'd3);
    cfg_write(2'd2, 8'h85);
    for (int i = 0; i < 3; i++) begin
      wait_start("t4_start");
      chk("t4_eval_t", 32'(eval_t), 32'(7 + i));
      dp_answer(1, 8'(8'h20 + i));
    end
    repeat (2) @(negedge clk);
    cfg_write(2'd3, 8'd0);
    chk("t4_clear_start", 32'(eval_start), 32'd1);
    chk("t4_clear_eval_t", 32'(eval_t), 32'd10);
    chk("t4_clear_overrun", 32'(overrun), 32'd0);
    chk("t4_ready_busy", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 8'h83;
    @(negedge clk);
    chk("t4_held_sel", 32'(eval_sel), 32'd5);
    chk("t4_held_ready", 32'(cfg_ready), 32'd0);
    eval_done = 1'b1; eval_sample = 8'hA5;
    @(negedge clk);
    eval_done = 1'b0;
    chk("t4_sample_out", 32'(sample_out), 32'hA5);
    chk("t4_ready_idle", 32'(cfg_ready), 32'd1);
    chk("t4_sel_not_yet", 32'(eval_sel), 32'd5);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("t4_sel_written", 32'(eval_sel), 32'd3);
    wait_start("t4_post_start");
    chk("t4_post_eval_t", 32'(eval_t), 32'd0);
    chk("t4_post_sel", 32'(eval_sel), 32'd3);
    dp_answer(1, 8'h31);

    // ena gap at cnt=2 with div=5
    stop_run();
    cfg_write(2'd0, 8'd5);
    cfg_write(2'd2, 8'h85);
    repeat (2) @(negedge clk);
    ena = 1'b0;
    saw_start = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (eval_start === 1'b1) saw_start = 1'b1;
    end
    chk("t5_no_tick_gap", 32'(saw_start), 32'd0);
    ena = 1'b1;
    wait_start("t5_start");
    chk("t5_resume_cycles", 32'(last_wait), 32'd4);
    // run=0 requested while busy, accepted once the evaluation finishes
    cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 8'h05;
    dp_answer(2, 8'h33);
    @(negedge clk);
    cfg_valid = 1'b0;
    saw_start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (eval_start === 1'b1) saw_start = 1'b1;
    end
    chk("t5_stopped", 32'(saw_start), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);

    // async reset mid-evaluation
    cfg_write(2'd2, 8'h85);
    wait_start("t6_start0");
    dp_answer(1, 8'h5A);
    wait_start("t6_start1");
    chk("t6_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("t6_rst_eval_start", 32'(eval_start), 32'd0);
    chk("t6_rst_eval_t", 32'(eval_t), 32'd0);
    chk("t6_rst_eval_sel", 32'(eval_sel), 32'd0);
    chk("t6_rst_sample_out", 32'(sample_out), 32'd0);
    chk("t6_rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("t6_rst_overrun", 32'(overrun), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    eval_done = 1'b1; eval_sample = 8'h77;
    @(negedge clk);
    eval_done = 1'b0;
    chk("t6_stray_sample_out", 32'(sample_out), 32'd0);
    chk("t6_stray_valid", 32'(sample_valid), 32'd0);
    chk("t6_stray_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
